// File: rtl/button_pio_debounced.sv
// rtl/button_pio_debounced.sv - Avalon-MM debounced input PIO with edge capture and level irq
module button_pio_debounced #(
    parameter int                WIDTH           = 4,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0]  IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_lvl;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]                  stable;
    logic [WIDTH-1:0]                  stable_d1;
    logic [WIDTH-1:0]                  edge_evt;
    logic [WIDTH-1:0]                  irq_mask;
    logic [WIDTH-1:0]                  edge_cap;
    logic [WIDTH-1:0]                  rise_en;
    logic [WIDTH-1:0]                  fall_en;
    logic [WIDTH-1:0]                  cap_clr;
    logic [31:0]                       rd_mux;
    logic                              wr;

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
        end
    endgenerate

    // Synchroniser resets to the idle level so no false press is seen out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= IDLE_LEVEL;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_lvl[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync_lvl[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign edge_evt = (stable & ~stable_d1 & rise_en) | (~stable & stable_d1 & fall_en);
    assign wr       = chipselect && !write_n;
    assign cap_clr  = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

    // A new event in the same cycle as a W1C on that bit keeps the bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d1 <= IDLE_LEVEL;
            edge_cap  <= '0;
            irq_mask  <= '0;
            rise_en   <= '0;
            fall_en   <= '1;
        end else begin
            stable_d1 <= stable;
            edge_cap  <= (edge_cap & ~cap_clr) | edge_evt;
            if (wr && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
            if (wr && address == 3'd4) rise_en  <= writedata[WIDTH-1:0];
            if (wr && address == 3'd5) fall_en  <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = 32'(stable);
            3'd1:    rd_mux = 32'(sync_lvl);
            3'd2:    rd_mux = 32'(irq_mask);
            3'd3:    rd_mux = 32'(edge_cap);
            3'd4:    rd_mux = 32'(rise_en);
            3'd5:    rd_mux = 32'(fall_en);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_button_pio_debounced.sv
// tb/tb_button_pio_debounced.sv - table, directed and randomized checks of button_pio_debounced
module tb_button_pio_debounced;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  in_port;

    button_pio_debounced #(
        .WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(4'hF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .in_port(in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pin history delayed by S edges, and a window of the last D
    // synchronised samples; a bit flips when the whole window disagrees with it.
    logic [3:0]  pin_hist[$];
    logic [3:0]  win[$];
    logic [3:0]  m_stable, m_d1, m_mask, m_cap, m_rise, m_fall;
    logic [31:0] m_rd;
    logic        m_irq;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl[11];
    logic [31:0] reset_exp[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        pin_hist.delete();
        win.delete();
        for (int i = 0; i < S; i++) pin_hist.push_back(4'hF);
        m_stable = 4'hF; m_d1 = 4'hF; m_mask = 4'h0; m_cap = 4'h0;
        m_rise = 4'h0; m_fall = 4'hF; m_rd = 32'h0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] pre_sync, ev, clr, nxt;
        logic       wr, all_diff;
        pre_sync = pin_hist.pop_front();
        pin_hist.push_back(in_port);
        case (address)
            3'd0:    m_rd = {28'd0, m_stable};
            3'd1:    m_rd = {28'd0, pre_sync};
            3'd2:    m_rd = {28'd0, m_mask};
            3'd3:    m_rd = {28'd0, m_cap};
            3'd4:    m_rd = {28'd0, m_rise};
            3'd5:    m_rd = {28'd0, m_fall};
            default: m_rd = 32'h0;
        endcase
        ev    = (m_stable & ~m_d1 & m_rise) | (~m_stable & m_d1 & m_fall);
        wr    = chipselect && !write_n;
        clr   = (wr && address == 3'd3) ? writedata[3:0] : 4'h0;
        m_cap = (m_cap & ~clr) | ev;
        if (wr && address == 3'd2) m_mask = writedata[3:0];
        if (wr && address == 3'd4) m_rise = writedata[3:0];
        if (wr && address == 3'd5) m_fall = writedata[3:0];
        win.push_back(pre_sync);
        if (win.size() > D) void'(win.pop_front());
        nxt = m_stable;
        if (win.size() == D) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                foreach (win[j]) if (win[j][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) nxt[b] = ~m_stable[b];
            end
        end
        m_d1     = m_stable;
        m_stable = nxt;
        m_irq    = |(m_cap & m_mask);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        cycle();
        d = readdata;
    endtask

    task automatic do_reset(input logic [3:0] pins_after);
        reset_n = 1'b0;
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        in_port = pins_after;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        writedata = 32'h0; in_port = 4'hF;
        model_reset();

        reset_exp = '{32'hF, 32'hF, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0};
        tbl[0]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hF};
        tbl[1]  = '{1'b1, 3'd2, 32'h0,         32'h0};
        tbl[2]  = '{1'b1, 3'd0, 32'h0,         32'hF};
        tbl[3]  = '{1'b1, 3'd1, 32'h0,         32'hF};
        tbl[4]  = '{1'b1, 3'd6, 32'hF,         32'h0};
        tbl[5]  = '{1'b1, 3'd7, 32'hF,         32'h0};
        tbl[6]  = '{1'b1, 3'd4, 32'hA,         32'hA};
        tbl[7]  = '{1'b1, 3'd4, 32'h0,         32'h0};
        tbl[8]  = '{1'b1, 3'd5, 32'h3,         32'h3};
        tbl[9]  = '{1'b1, 3'd5, 32'hF,         32'hF};
        tbl[10] = '{1'b1, 3'd3, 32'hF,         32'h0};

        #1;
        do_reset(4'hF);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("reset_read_addr%0d", a), rd, reset_exp[a]);
        end
        check("reset_irq_idle", {31'd0, irq}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
            bus_read(tbl[i].addr, rd);
            check($sformatf("reg_vec%0d", i), rd, tbl[i].exp_rd);
        end

        // Press bit0: debounced level lands on edge 6, capture and irq on edge 7
        bus_write(3'd2, 32'h1);
        address = 3'd0;
        in_port = 4'hE;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            if (k == 6) begin
                check("press_data_edge6", readdata, 32'hF);
                check("press_irq_edge6", {31'd0, irq}, 32'h0);
            end
            if (k == 7) begin
                check("press_data_edge7", readdata, 32'hE);
                check("press_irq_edge7", {31'd0, irq}, 32'h1);
            end
        end
        bus_read(3'd3, rd);
        check("press_capture", rd, 32'h1);
        bus_write(3'd3, 32'h1);
        check("w1c_irq_drop", {31'd0, irq}, 32'h0);

        // Glitch one cycle shorter than the debounce window is rejected
        in_port = 4'hC;
        repeat (D - 1) cycle();
        in_port = 4'hE;
        repeat (8) cycle();
        bus_read(3'd0, rd);
        check("glitch3_data", rd, 32'hE);
        bus_read(3'd3, rd);
        check("glitch3_capture", rd, 32'h0);

        // A pulse of exactly the window length is accepted
        in_port = 4'hC;
        repeat (D) cycle();
        in_port = 4'hE;
        repeat (12) cycle();
        bus_read(3'd3, rd);
        check("pulse4_capture", rd, 32'h2);
        bus_read(3'd0, rd);
        check("pulse4_data", rd, 32'hE);
        bus_write(3'd3, 32'h2);

        // Rising-only enable
        bus_write(3'd4, 32'h1);
        bus_write(3'd5, 32'h0);
        in_port = 4'hF;
        repeat (10) cycle();
        bus_read(3'd3, rd);
        check("rise_capture", rd, 32'h1);
        check("rise_irq", {31'd0, irq}, 32'h1);
        bus_write(3'd3, 32'h1);
        in_port = 4'hE;
        repeat (10) cycle();
        bus_read(3'd3, rd);
        check("fall_ignored", rd, 32'h0);

        // Selective W1C and set-wins-over-clear
        bus_write(3'd4, 32'h3);
        bus_write(3'd5, 32'h2);
        in_port = 4'hC;
        repeat (10) cycle();
        in_port = 4'hD;
        repeat (10) cycle();
        bus_read(3'd3, rd);
        check("cap_both", rd, 32'h3);
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        check("w1c_bit0", rd, 32'h2);
        check("w1c_bit0_irq", {31'd0, irq}, 32'h0);
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, rd);
        check("w1c_bit1", rd, 32'h0);
        in_port = 4'hF;
        repeat (S + D) cycle();
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, rd);
        check("set_wins", rd, 32'h2);

        // Reset mid-count discards everything
        bus_write(3'd2, 32'hF);
        check("pre_reset_irq", {31'd0, irq}, 32'h1);
        in_port = 4'h0;
        repeat (S + 2) cycle();
        do_reset(4'hF);
        bus_read(3'd0, rd);
        check("post_reset_data", rd, 32'hF);
        bus_read(3'd3, rd);
        check("post_reset_capture", rd, 32'h0);
        bus_read(3'd5, rd);
        check("post_reset_fall_en", rd, 32'hF);
        check("post_reset_irq", {31'd0, irq}, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset(in_port);
            if ($urandom_range(7) == 0) in_port = in_port ^ 4'($urandom_range(15));
            chipselect = ($urandom_range(3) == 0);
            write_n    = 1'($urandom_range(1));
            address    = 3'($urandom_range(7));
            writedata  = $urandom;
            cycle();
            check($sformatf("rand_readdata_%0d", n), readdata, m_rd);
            check($sformatf("rand_irq_%0d", n), {31'd0, irq}, {31'd0, m_irq});
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
